// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: turns push/pop into storage strobes and addresses (FIFO_ERR_FLAGS_EN adds sticky error flags).
// Latency: wr/rd are combinational in the request cycle; pointers, count and flags update on the next clk edge.
// Backpressure: push is refused while full unless a pop is accepted in the same cycle; pop is refused while empty.
module fifo_ctrl #(
    parameter int depth = 8,
    localparam int as = $clog2(depth)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    output logic          wr,
    output logic          rd,
    output logic [as-1:0] AddrWr,
    output logic [as-1:0] AddrRd,
    output logic          full,
    output logic          empty,
    output logic [as:0]   count,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } state_t;

    localparam logic [as-1:0] ptr_last   = as'(depth - 1);
    localparam logic [as-1:0] ptr_one    = as'(1);
    localparam logic [as:0]   cnt_one    = (as+1)'(1);
    localparam logic [as:0]   cnt_almost = (as+1)'(depth - 1);

    state_t        state, state_nxt;
    logic [as-1:0] wr_ptr, rd_ptr;
    logic [as:0]   cnt_q;

    assign full   = (state == FULL);
    assign empty  = (state == EMPTY);
    assign AddrWr = wr_ptr;
    assign AddrRd = rd_ptr;
    assign count  = cnt_q;

    // No bypass: a pop on an empty FIFO is refused even alongside a push.
    assign rd = pop & ~empty & ~reset;
    assign wr = push & (~full | pop) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (wr && !rd) state_nxt = PARTIAL;
            end
            PARTIAL: begin
                if (wr && !rd && cnt_q == cnt_almost) state_nxt = FULL;
                else if (rd && !wr && cnt_q == cnt_one) state_nxt = EMPTY;
            end
            FULL: begin
                if (rd && !wr) state_nxt = PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Explicit wrap keeps non-power-of-two depths inside the storage range.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) wr_ptr <= (wr_ptr == ptr_last) ? '0 : wr_ptr + ptr_one;
            if (rd) rd_ptr <= (rd_ptr == ptr_last) ? '0 : rd_ptr + ptr_one;
            if (wr && !rd)      cnt_q <= cnt_q + cnt_one;
            else if (rd && !wr) cnt_q <= cnt_q - cnt_one;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && !wr) ovf_q <= 1'b1;
            if (pop && !rd)  unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
